// File: rtl/capi_jctrl_arb_sm.sv
// -----------------------------------------------------------------------------
// capi_jctrl_arb_sm
//
// Job-control quiesce sequencer for the AFU command path. Each channel may post
// one control command into its own holding slot. Pending slots are served one
// at a time in round-robin order. Serving a command means:
//   1. drop the AFU command issue enable and wait a settle delay,
//   2. wait for the outstanding-command count to drain to zero (or give up
//      after a programmable quiet timeout),
//   3. pulse the command out for execution and wait for its completion,
//   4. free the slot and re-enable AFU command issue.
// The block also keeps the AFU outstanding-command count, saturating on
// overflow and flagging responses that arrive while the count is zero.
//
// Ports
//   clk          clock, all state on the rising edge
//   reset        synchronous, active-high
//   i_cmd_v      per-channel command valid
//   i_cmd_d      per-channel payload, channel k in [k*cmd_width +: cmd_width]
//   o_cmd_r      per-channel ready (holding slot empty)
//   i_cmd_cmpl   execution-complete pulse for the active command
//   o_cmd_v      execute pulse (combinational, in the QUIET exit cycle)
//   o_cmd_d      payload of the active command (QUIET through EXECUTE)
//   o_cmd_ch     channel index of the active command (QUIET through EXECUTE)
//   o_cmd_forced qualifies o_cmd_v: issued after a quiet timeout
//   i_cmd_sent   AFU command issued (outstanding +1)
//   i_rsp_rcvd   AFU response received (outstanding -1)
//   o_cmd_en     AFU command issue enable (registered, 1 iff IDLE last cycle)
//   i_cfg_dly    settle delay in cycles, 0 behaves as 1
//   i_cfg_to     quiet timeout in cycles, 0 disables the timeout
//   o_outst      current outstanding count
//   o_err_to     pulse on quiet timeout
//   o_err_uf     pulse on a response received while the count is zero
// -----------------------------------------------------------------------------
module capi_jctrl_arb_sm #(
  parameter int channels   = 4,
  parameter int ch_width   = 2,
  parameter int cmd_width  = 8,
  parameter int cred_width = 8,
  parameter int dly_width  = 4,
  parameter int to_width   = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [channels-1:0]             i_cmd_v,
  input  logic [channels*cmd_width-1:0]   i_cmd_d,
  output logic [channels-1:0]             o_cmd_r,
  input  logic                            i_cmd_cmpl,
  output logic                            o_cmd_v,
  output logic [cmd_width-1:0]            o_cmd_d,
  output logic [ch_width-1:0]             o_cmd_ch,
  output logic                            o_cmd_forced,
  input  logic                            i_cmd_sent,
  input  logic                            i_rsp_rcvd,
  output logic                            o_cmd_en,
  input  logic [dly_width-1:0]            i_cfg_dly,
  input  logic [to_width-1:0]             i_cfg_to,
  output logic [cred_width-1:0]           o_outst,
  output logic                            o_err_to,
  output logic                            o_err_uf
);

  // One extra bit so (pointer + offset) never wraps before the modulo step.
  localparam int IW = ch_width + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DISABLE = 2'd1,
    ST_QUIET   = 2'd2,
    ST_EXECUTE = 2'd3
  } state_t;

  state_t                 state_q;
  state_t                 state_d;

  logic [channels-1:0]    slot_full_q;
  logic [cmd_width-1:0]   slot_d_q [channels];
  logic [channels-1:0]    cap_vec;
  logic [channels-1:0]    free_vec;
  logic                   any_full;

  // Doubles as the round-robin pointer (last granted) and the active grant.
  logic [ch_width-1:0]    gnt_q;
  logic [ch_width-1:0]    arb_idx;

  logic [dly_width-1:0]   dly_cnt_q;
  logic [to_width-1:0]    to_cnt_q;
  logic [cred_width-1:0]  outst_q;
  logic                   cmd_en_q;

  logic                   grant_now;
  logic                   quiet_drain;
  logic                   quiet_force;
  logic                   quiet_exit;

  // Saturating up/down update of the outstanding count; simultaneous inc and
  // dec cancel, underflow holds at zero (flagged separately).
  function automatic logic [cred_width-1:0] outst_upd(
    input logic [cred_width-1:0] cur,
    input logic                  inc,
    input logic                  dec
  );
    logic [cred_width-1:0] nxt;
    nxt = cur;
    if (inc && !dec && (cur != {cred_width{1'b1}})) begin
      nxt = cur + 1'b1;
    end else if (dec && !inc && (cur != '0)) begin
      nxt = cur - 1'b1;
    end
    return nxt;
  endfunction

  // Zero delay behaves as a single settle cycle.
  function automatic logic [dly_width-1:0] dly_load(input logic [dly_width-1:0] cfg);
    return (cfg == '0) ? dly_width'(1) : cfg;
  endfunction

  // ---------------------------------------------------------------------------
  // Holding slots: capture/free decode
  // ---------------------------------------------------------------------------
  always_comb begin
    cap_vec  = '0;
    free_vec = '0;
    for (int k = 0; k < channels; k++) begin
      cap_vec[k]  = i_cmd_v[k] & ~slot_full_q[k] & ~reset;
      free_vec[k] = (state_q == ST_EXECUTE) & i_cmd_cmpl & (gnt_q == ch_width'(k));
    end
  end

  assign any_full = |slot_full_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_full_q <= '0;
    end else begin
      slot_full_q <= (slot_full_q & ~free_vec) | cap_vec;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < channels; k++) begin
      if (cap_vec[k]) begin
        slot_d_q[k] <= i_cmd_d[k*cmd_width +: cmd_width];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin arbiter: first full slot after the last grant
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [IW-1:0] idx_w;
    logic          hit;
    arb_idx = gnt_q;
    hit     = 1'b0;
    idx_w   = '0;
    for (int i = 1; i <= channels; i++) begin
      idx_w = {1'b0, gnt_q} + IW'(i);
      if (idx_w >= IW'(channels)) begin
        idx_w = idx_w - IW'(channels);
      end
      if (!hit && slot_full_q[idx_w[ch_width-1:0]]) begin
        hit     = 1'b1;
        arb_idx = idx_w[ch_width-1:0];
      end
    end
  end

  assign grant_now = (state_q == ST_IDLE) & any_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_q <= ch_width'(channels - 1);
    end else if (grant_now) begin
      gnt_q <= arb_idx;
    end
  end

  // ---------------------------------------------------------------------------
  // Settle-delay and quiet-timeout counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      dly_cnt_q <= '0;
    end else if (grant_now) begin
      dly_cnt_q <= dly_load(i_cfg_dly);
    end else if (state_q == ST_DISABLE) begin
      dly_cnt_q <= dly_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt_q <= '0;
    end else if (state_q == ST_QUIET) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end else begin
      to_cnt_q <= '0;
    end
  end

  // The drain test deliberately uses the registered count, so a response in
  // cycle n lets the command go out in cycle n+1 at the earliest.
  assign quiet_drain = (outst_q == '0);
  assign quiet_force = ~quiet_drain & (i_cfg_to != '0) &
                       (to_cnt_q == (i_cfg_to - to_width'(1)));
  assign quiet_exit  = quiet_drain | quiet_force;

  // ---------------------------------------------------------------------------
  // Sequencer FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (any_full) begin
          state_d = ST_DISABLE;
        end
      end
      ST_DISABLE: begin
        if (dly_cnt_q == dly_width'(1)) begin
          state_d = ST_QUIET;
        end
      end
      ST_QUIET: begin
        if (quiet_exit) begin
          state_d = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        if (i_cmd_cmpl) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    o_cmd_v      = 1'b0;
    o_cmd_forced = 1'b0;
    o_err_to     = 1'b0;
    o_cmd_d      = '0;
    o_cmd_ch     = '0;
    if (state_q == ST_QUIET) begin
      o_cmd_v      = quiet_exit;
      o_cmd_forced = quiet_force;
      o_err_to     = quiet_force;
    end
    if ((state_q == ST_QUIET) || (state_q == ST_EXECUTE)) begin
      o_cmd_d  = slot_d_q[gnt_q];
      o_cmd_ch = gnt_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Issue enable and outstanding-count registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_en_q <= 1'b0;
      outst_q  <= '0;
    end else begin
      cmd_en_q <= (state_q == ST_IDLE);
      outst_q  <= outst_upd(outst_q, i_cmd_sent, i_rsp_rcvd);
    end
  end

  assign o_cmd_en = cmd_en_q;
  assign o_outst  = outst_q;
  // Slots are forced to read as empty during reset; captures are already
  // suppressed by cap_vec.
  assign o_cmd_r  = reset ? {channels{1'b1}} : ~slot_full_q;
  assign o_err_uf = ~reset & i_rsp_rcvd & ~i_cmd_sent & (outst_q == '0);

endmodule

// File: tb/tb_capi_jctrl_arb_sm.sv
// -----------------------------------------------------------------------------
// Testbench for capi_jctrl_arb_sm: directed stimulus, expected execute pulses
// queued in a scoreboard and checked by an independent monitor; timing and
// counter behaviour checked at fixed cycle offsets.
// -----------------------------------------------------------------------------
module tb_capi_jctrl_arb_sm;

  typedef struct packed {
    logic [1:0] ch;
    logic [7:0] d;
    logic       forced;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [3:0]  i_cmd_v;
  logic [31:0] i_cmd_d;
  logic [3:0]  o_cmd_r;
  logic        i_cmd_cmpl;
  logic        o_cmd_v;
  logic [7:0]  o_cmd_d;
  logic [1:0]  o_cmd_ch;
  logic        o_cmd_forced;
  logic        i_cmd_sent;
  logic        i_rsp_rcvd;
  logic        o_cmd_en;
  logic [3:0]  i_cfg_dly;
  logic [15:0] i_cfg_to;
  logic [7:0]  o_outst;
  logic        o_err_to;
  logic        o_err_uf;

  // Narrow-counter instance for saturation
  logic        s2_sent;
  logic [3:0]  s2_cmd_r;
  logic        s2_cmd_v;
  logic [7:0]  s2_cmd_d;
  logic [1:0]  s2_cmd_ch;
  logic        s2_forced;
  logic        s2_en;
  logic [1:0]  s2_outst;
  logic        s2_err_to;
  logic        s2_err_uf;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  capi_jctrl_arb_sm #(
    .channels(4), .ch_width(2), .cmd_width(8),
    .cred_width(8), .dly_width(4), .to_width(16)
  ) dut (
    .clk(clk), .reset(reset),
    .i_cmd_v(i_cmd_v), .i_cmd_d(i_cmd_d), .o_cmd_r(o_cmd_r),
    .i_cmd_cmpl(i_cmd_cmpl), .o_cmd_v(o_cmd_v), .o_cmd_d(o_cmd_d),
    .o_cmd_ch(o_cmd_ch), .o_cmd_forced(o_cmd_forced),
    .i_cmd_sent(i_cmd_sent), .i_rsp_rcvd(i_rsp_rcvd), .o_cmd_en(o_cmd_en),
    .i_cfg_dly(i_cfg_dly), .i_cfg_to(i_cfg_to), .o_outst(o_outst),
    .o_err_to(o_err_to), .o_err_uf(o_err_uf)
  );

  capi_jctrl_arb_sm #(
    .channels(4), .ch_width(2), .cmd_width(8),
    .cred_width(2), .dly_width(4), .to_width(16)
  ) dut2 (
    .clk(clk), .reset(reset),
    .i_cmd_v(4'b0000), .i_cmd_d(32'h0), .o_cmd_r(s2_cmd_r),
    .i_cmd_cmpl(1'b0), .o_cmd_v(s2_cmd_v), .o_cmd_d(s2_cmd_d),
    .o_cmd_ch(s2_cmd_ch), .o_cmd_forced(s2_forced),
    .i_cmd_sent(s2_sent), .i_rsp_rcvd(1'b0), .o_cmd_en(s2_en),
    .i_cfg_dly(4'd1), .i_cfg_to(16'd0), .o_outst(s2_outst),
    .o_err_to(s2_err_to), .o_err_uf(s2_err_uf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic push_exp(input logic [1:0] ch, input logic [7:0] d, input logic f);
    exp_t e;
    e.ch     = ch;
    e.d      = d;
    e.forced = f;
    exp_q.push_back(e);
  endtask

  task automatic wait_sb(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0) && (n < budget)) begin
      nxt();
      n++;
    end
    chk("sb_pending", exp_q.size(), 0);
  endtask

  // Monitor: every execute pulse must match the oldest expected command.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (o_cmd_v === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected actual ch=%0d d=%0h required=none", o_cmd_ch, o_cmd_d);
        end else begin
          e = exp_q.pop_front();
          chk("sb_ch", o_cmd_ch, e.ch);
          chk("sb_data", o_cmd_d, e.d);
          chk("sb_forced", o_cmd_forced, e.forced);
          chk("sb_err_to", o_err_to, e.forced);
        end
      end
    end
  end

  // Executor model: completes each command one cycle after it is issued.
  initial begin : responder
    i_cmd_cmpl = 1'b0;
    forever begin
      @(negedge clk);
      if (o_cmd_v === 1'b1) begin
        @(posedge clk);
        #1 i_cmd_cmpl = 1'b1;
        @(posedge clk);
        #1 i_cmd_cmpl = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "simulation did not finish");
  end

  initial begin : stim
    int sat_exp[5];
    int n;
    sat_exp = '{1, 2, 3, 3, 3};

    reset      = 1'b1;
    i_cmd_v    = '0;
    i_cmd_d    = '0;
    i_cmd_sent = 1'b0;
    i_rsp_rcvd = 1'b0;
    s2_sent    = 1'b0;
    i_cfg_dly  = 4'd3;
    i_cfg_to   = 16'd0;

    // Reset state
    repeat (2) nxt();
    smp();
    chk("rst_ready_in_reset", o_cmd_r, 4'hF);
    chk("rst_en_in_reset", o_cmd_en, 0);
    nxt(); reset = 1'b0;
    smp();
    chk("rst_en_first", o_cmd_en, 0);
    chk("rst_outst", o_outst, 0);
    chk("rst_cmd_v", o_cmd_v, 0);
    chk("rst_ch", o_cmd_ch, 0);
    chk("rst_errs", {o_cmd_forced, o_err_to, o_err_uf}, 0);
    chk("rst_ready", o_cmd_r, 4'hF);
    nxt(); smp();
    chk("rst_en_after", o_cmd_en, 1);

    // Single command: ch0, dly=3, outstanding 0
    nxt();
    i_cmd_v = 4'b0001; i_cmd_d[7:0] = 8'hA5;
    push_exp(2'd0, 8'hA5, 1'b0);
    smp(); chk("t1_ready_t0", o_cmd_r, 4'hF);
    nxt(); i_cmd_v = '0;
    smp(); chk("t1_ready_t1", o_cmd_r, 4'hE);
    nxt(); smp(); chk("t1_en_t2", o_cmd_en, 1);
    nxt(); smp(); chk("t1_en_t3", o_cmd_en, 0);
    nxt(); smp(); chk("t1_v_t4", o_cmd_v, 0);
    nxt(); smp(); chk("t1_v_t5", o_cmd_v, 1);
    nxt(); smp(); chk("t1_en_t6", o_cmd_en, 0);
    nxt(); smp(); chk("t1_ready_t7", o_cmd_r, 4'hF); chk("t1_en_t7", o_cmd_en, 0);
    nxt(); smp(); chk("t1_en_t8", o_cmd_en, 1);
    wait_sb(20);
    repeat (3) nxt();

    // Drain wait: 5 outstanding, no timeout, ch2 with dly=1
    i_cfg_dly = 4'd1;
    i_cmd_sent = 1'b1;
    repeat (4) nxt();
    nxt(); i_cmd_sent = 1'b0;
    smp(); chk("t2_outst5", o_outst, 5);
    nxt();
    i_cmd_v = 4'b0100; i_cmd_d[23:16] = 8'h3C;
    push_exp(2'd2, 8'h3C, 1'b0);
    nxt(); i_cmd_v = '0;
    repeat (3) nxt();
    smp(); chk("t2_hold_quiet", o_cmd_v, 0);
    nxt(); i_rsp_rcvd = 1'b1;
    repeat (4) nxt();
    smp();
    chk("t2_v_before_zero", o_cmd_v, 0);
    chk("t2_outst1", o_outst, 1);
    chk("t2_no_uf", o_err_uf, 0);
    nxt(); i_rsp_rcvd = 1'b0;
    smp();
    chk("t2_outst0", o_outst, 0);
    chk("t2_v_at_zero", o_cmd_v, 1);
    chk("t2_not_forced", o_cmd_forced, 0);
    wait_sb(20);
    repeat (4) nxt();

    // Timeout: outstanding 2 held, to=8, ch3
    i_cfg_to = 16'd8;
    i_cmd_sent = 1'b1;
    nxt();
    nxt(); i_cmd_sent = 1'b0;
    smp(); chk("t3_outst2", o_outst, 2);
    nxt();
    i_cmd_v = 4'b1000; i_cmd_d[31:24] = 8'h81;
    push_exp(2'd3, 8'h81, 1'b1);
    nxt(); i_cmd_v = '0;
    repeat (8) nxt();
    smp();
    chk("t3_v_q7", o_cmd_v, 0);
    chk("t3_err_q7", o_err_to, 0);
    nxt(); smp();
    chk("t3_v_q8", o_cmd_v, 1);
    chk("t3_forced_q8", o_cmd_forced, 1);
    chk("t3_err_q8", o_err_to, 1);
    wait_sb(20);
    repeat (4) nxt();
    i_cfg_to = 16'd0;
    i_rsp_rcvd = 1'b1;
    nxt();
    nxt(); i_rsp_rcvd = 1'b0;
    smp(); chk("t3_drained", o_outst, 0);

    // Round-robin: all four at once, ch1 re-posts while its slot is busy
    nxt();
    i_cmd_v = 4'b1111;
    i_cmd_d = {8'h13, 8'h12, 8'h11, 8'h10};
    push_exp(2'd0, 8'h10, 1'b0);
    push_exp(2'd1, 8'h11, 1'b0);
    push_exp(2'd2, 8'h12, 1'b0);
    push_exp(2'd3, 8'h13, 1'b0);
    push_exp(2'd1, 8'h21, 1'b0);
    nxt();
    i_cmd_v = 4'b0010; i_cmd_d[15:8] = 8'h21;
    smp(); chk("t4_slots_full", o_cmd_r, 4'h0);
    n = 0;
    while ((o_cmd_r[1] !== 1'b1) && (n < 100)) begin
      nxt(); smp();
      n++;
    end
    chk("t4_repost_ready", o_cmd_r[1], 1);
    nxt(); i_cmd_v = '0;
    wait_sb(100);
    repeat (4) nxt();

    // Counter edges
    i_cmd_sent = 1'b1;
    repeat (2) nxt();
    nxt(); i_rsp_rcvd = 1'b1;
    smp(); chk("t5_outst3", o_outst, 3);
    nxt(); i_cmd_sent = 1'b0;
    smp(); chk("t5_both_hold", o_outst, 3); chk("t5_dec_no_uf", o_err_uf, 0);
    repeat (3) nxt();
    smp(); chk("t5_outst0", o_outst, 0); chk("t5_uf_pulse", o_err_uf, 1);
    nxt(); i_rsp_rcvd = 1'b0;
    smp(); chk("t5_uf_hold0", o_outst, 0); chk("t5_uf_clear", o_err_uf, 0);

    nxt(); s2_sent = 1'b1;
    for (int i = 0; i < 5; i++) begin
      nxt();
      if (i == 4) s2_sent = 1'b0;
      smp();
      chk("t5_sat_step", s2_outst, sat_exp[i]);
    end
    chk("t5_dut2_idle",
        {s2_cmd_r, s2_cmd_v, s2_cmd_d, s2_cmd_ch, s2_forced, s2_en, s2_err_to, s2_err_uf},
        {4'hF, 1'b0, 8'h00, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0});

    // Reset mid-QUIET with two slots full
    nxt(); i_cmd_sent = 1'b1;
    nxt();
    nxt(); i_cmd_sent = 1'b0;
    i_cmd_v = 4'b0011; i_cmd_d[7:0] = 8'h55; i_cmd_d[15:8] = 8'h66;
    nxt(); i_cmd_v = '0;
    nxt();
    nxt();
    smp();
    chk("t6_slots_full", o_cmd_r, 4'hC);
    chk("t6_quiet_hold", o_cmd_v, 0);
    chk("t6_outst2", o_outst, 2);
    nxt(); reset = 1'b1;
    smp(); chk("t6_ready_in_reset", o_cmd_r, 4'hF);
    nxt(); reset = 1'b0;
    smp();
    chk("t6_ready_after", o_cmd_r, 4'hF);
    chk("t6_outst_after", o_outst, 0);
    chk("t6_v_after", o_cmd_v, 0);
    chk("t6_en_after", o_cmd_en, 0);
    nxt(); smp(); chk("t6_en_up", o_cmd_en, 1);
    nxt();
    nxt(); smp();
    chk("t6_stays_idle", o_cmd_en, 1);
    chk("t6_no_v", o_cmd_v, 0);

    repeat (3) nxt();
    chk("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
